// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator and its
// companion sequence detector.
package seq_pkg;

  localparam int DEFAULT_MAX_LEN = 16;

  // Canonical stimulus for the 1011 sequence detector.
  localparam logic [3:0] SEQ_1011 = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    DONE
  } gen_state_t;

endpackage

// File: rtl/seq_bit_shifter.sv
// Holds the captured pattern and walks a bit index from len-1 down to 0.
// The selected bit is registered and reads 0 whenever no bit is being sent.
module seq_bit_shifter
  import seq_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               reload,
  input  logic               advance,
  input  logic [MAX_LEN-1:0] data,
  input  logic [LEN_W-1:0]   len,
  output logic               sel_bit,
  output logic               last
);

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic               bit_q;

  // Shift-based select keeps the index width independent of the vector width.
  function automatic logic pick(input logic [MAX_LEN-1:0] v, input logic [LEN_W-1:0] i);
    logic [MAX_LEN-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      bit_q <= 1'b0;
    end else if (load) begin
      pat_q <= data;
      len_q <= len;
      idx_q <= len - LEN_W'(1);
      bit_q <= pick(data, len - LEN_W'(1));
    end else if (reload) begin
      idx_q <= len_q - LEN_W'(1);
      bit_q <= pick(pat_q, len_q - LEN_W'(1));
    end else if (advance) begin
      idx_q <= idx_q - LEN_W'(1);
      bit_q <= pick(pat_q, idx_q - LEN_W'(1));
    end else begin
      bit_q <= 1'b0;
    end
  end

  assign sel_bit = bit_q;
  assign last    = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: accepts a pattern command over valid/ready and
// emits it MSB-first, with repetitions separated by idle gaps.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = 8,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  // Handshake: a command transfers on a rising edge where pat_valid and
  // pat_ready are both 1; pat_ready is 1 only in IDLE, so an offered command
  // is held off (never dropped) while a previous one is in progress.
  input  logic               pat_valid,
  output logic               pat_ready,
  input  logic [MAX_LEN-1:0] pat_data,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic [CNT_W-1:0]   pat_repeat,
  input  logic [GAP_W-1:0]   pat_gap,
  output logic               out_bit,
  output logic               out_valid,
  output logic               busy,
  output logic               done,
  output gen_state_t         fsm_state
);

  gen_state_t       state, state_next;
  logic [CNT_W-1:0] rep_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic             out_valid_q;
  logic             done_q;
  logic             load, reload, advance, last;
  logic [LEN_W-1:0] eff_len;

  assign eff_len = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;

  seq_bit_shifter #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .reload (reload),
    .advance(advance),
    .data   (pat_data),
    .len    (eff_len),
    .sel_bit(out_bit),
    .last   (last)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    reload     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (pat_valid) begin
          if (eff_len == '0) begin
            state_next = DONE;
          end else begin
            state_next = SHIFT;
            load       = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (!last) begin
          advance = 1'b1;
        end else if (rep_q > CNT_W'(1)) begin
          if (gap_q != '0) state_next = GAP;
          else             reload     = 1'b1;
        end else begin
          state_next = DONE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          state_next = SHIFT;
          reload     = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rep_q       <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_next;
      out_valid_q <= (state_next == SHIFT);
      done_q      <= (state_next == DONE);
      if (state == IDLE && pat_valid) begin
        // Zero repeats is substituted here so the counter can never wrap.
        rep_q <= (pat_repeat == '0) ? CNT_W'(1) : pat_repeat;
        gap_q <= pat_gap;
      end
      if (state == SHIFT && last) rep_q <= rep_q - CNT_W'(1);
      if (state == SHIFT && state_next == GAP) gap_cnt <= gap_q;
      else if (state == GAP)                   gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  assign pat_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign fsm_state = state;

endmodule
